controle_somador_complemento7b: RTL and testbench

- Sequential control stage wrapped around the 7-bit ones'-complement adder/subtractor.
- Captures operands and drives the external adder's `sinal`/`a`/`b`/`cin`, then consumes its `s`/`cout`.
- Performs the end-around-carry correction as a second adder pass.
- Registers the result with overflow and zero flags, and optionally accumulates results across operations.

---
 rtl/controle_somador_complemento7b.sv | 174 +++++++++++++++++
 tb/tb_controle_somador_complemento7b.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/controle_somador_complemento7b.sv
// -----------------------------------------------------------------------------
// controle_somador_complemento7b
//
// Sequential control stage for an external LARGURA-bit ones'-complement
// adder/subtractor. One operation runs as up to two adder passes: pass 1
// computes A +/- B, and pass 2 (only when pass 1 carries out) adds the
// end-around carry back in. The final value is registered together with
// overflow and zero flags. Operand A may come from the accumulator
// (the registered result) instead of the `a` input.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   inicio          start request, honoured only while idle
//   sinal           0 = A+B, 1 = A-B
//   acumula         1 = take operand A from resultado instead of `a`
//   a, b            operands, ones' complement
//   add_sinal/add_a/add_b/add_cin   drive the external adder
//   add_s/add_cout  results coming back from the external adder
//   resultado       registered result, also the accumulator
//   overflow        ones'-complement overflow of the last operation
//   zero            resultado is zero (+0, or -0 when not normalised)
//   ocupado         high while an adder pass is in progress
//   pronto          one-cycle pulse when a new result is available
// -----------------------------------------------------------------------------
module controle_somador_complemento7b #(
    parameter int LARGURA        = 7,
    parameter bit NORMALIZA_ZERO = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inicio,
    input  logic               sinal,
    input  logic               acumula,
    input  logic [LARGURA-1:0] a,
    input  logic [LARGURA-1:0] b,
    output logic               add_sinal,
    output logic [LARGURA-1:0] add_a,
    output logic [LARGURA-1:0] add_b,
    output logic               add_cin,
    input  logic [LARGURA-1:0] add_s,
    input  logic               add_cout,
    output logic [LARGURA-1:0] resultado,
    output logic               overflow,
    output logic               zero,
    output logic               ocupado,
    output logic               pronto
);

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        PASSO1 = 2'd1,
        PASSO2 = 2'd2,
        FIM    = 2'd3
    } estado_t;

    estado_t            r_estado;
    estado_t            w_prox;

    logic [LARGURA-1:0] r_op_a;
    logic [LARGURA-1:0] r_op_b;
    logic               r_op_sinal;
    logic [LARGURA-1:0] r_tmp;
    logic               r_sa;
    logic               r_sb;
    logic [LARGURA-1:0] r_resultado;
    logic               r_overflow;
    logic               r_zero;
    logic               r_ocupado;
    logic               r_pronto;

    logic               w_sa;
    logic               w_sb;
    logic               w_fin_um;
    logic [LARGURA-1:0] w_res_final;
    logic               w_ovf;
    logic               w_zero;

    // Operand signs. In PASSO1 the sign registers are being loaded on the same
    // edge that may enter FIM, so the flags use the live decode there and the
    // registered copy in PASSO2.
    assign w_sa = (r_estado == PASSO2) ? r_sa : r_op_a[LARGURA-1];
    assign w_sb = (r_estado == PASSO2) ? r_sb : (r_op_b[LARGURA-1] ^ r_op_sinal);

    // Final value is whatever the adder returns in the last pass.
    assign w_fin_um    = &add_s;
    assign w_res_final = (NORMALIZA_ZERO && w_fin_um) ? '0 : add_s;
    // Overflow is judged on the raw adder value, before -0 is normalised.
    assign w_ovf       = (w_sa == w_sb) && (add_s[LARGURA-1] != w_sa);
    assign w_zero      = (w_res_final == '0) || (!NORMALIZA_ZERO && w_fin_um);

    // Next state and adder drive.
    always_comb begin
        // NOTE: every output of this block gets a default first so that no
        // path through the case leaves a signal unassigned (no latches).
        w_prox    = r_estado;
        add_sinal = 1'b0;
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;
        case (r_estado)
            OCIOSO: begin
                if (inicio) begin
                    w_prox = PASSO1;
                end
            end
            PASSO1: begin
                add_sinal = r_op_sinal;
                add_a     = r_op_a;
                add_b     = r_op_b;
                w_prox    = add_cout ? PASSO2 : FIM;
            end
            PASSO2: begin
                // End-around carry: feed the pass-1 sum back with cin = 1.
                add_a   = r_tmp;
                add_cin = 1'b1;
                w_prox  = FIM;
            end
            FIM: begin
                w_prox = OCIOSO;
            end
            default: begin
                w_prox = OCIOSO;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_estado    <= OCIOSO;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_op_sinal  <= 1'b0;
            r_tmp       <= '0;
            r_sa        <= 1'b0;
            r_sb        <= 1'b0;
            r_resultado <= '0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b1;
            r_ocupado   <= 1'b0;
            r_pronto    <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            r_estado  <= w_prox;
            r_ocupado <= (w_prox == PASSO1) || (w_prox == PASSO2);
            r_pronto  <= (w_prox == FIM);

            if ((r_estado == OCIOSO) && inicio) begin
                r_op_a     <= acumula ? r_resultado : a;
                r_op_b     <= b;
                r_op_sinal <= sinal;
            end

            if (r_estado == PASSO1) begin
                r_tmp <= add_s;
                r_sa  <= r_op_a[LARGURA-1];
                r_sb  <= r_op_b[LARGURA-1] ^ r_op_sinal;
            end

            if (w_prox == FIM) begin
                r_resultado <= w_res_final;
                r_overflow  <= w_ovf;
                r_zero      <= w_zero;
            end
        end
    end

    assign resultado = r_resultado;
    assign overflow  = r_overflow;
    assign zero      = r_zero;
    assign ocupado   = r_ocupado;
    assign pronto    = r_pronto;

endmodule

// File: tb/tb_controle_somador_complemento7b.sv
// -----------------------------------------------------------------------------
// tb_controle_somador_complemento7b
//
// Two instances share all control inputs: dut1 with NORMALIZA_ZERO=1 and
// dut2 with NORMALIZA_ZERO=0. Each has its own behavioural ones'-complement
// adder. Expected results are queued when an operation starts and popped
// when pronto rises.
// -----------------------------------------------------------------------------
module tb_controle_somador_complemento7b;

    localparam int W = 7;

    logic         clk = 1'b0;
    logic         rst;
    logic         inicio;
    logic         sinal;
    logic         acumula;
    logic [W-1:0] a;
    logic [W-1:0] b;

    logic         add_sinal1, add_cin1, add_cout1;
    logic [W-1:0] add_a1, add_b1, add_s1, resultado1;
    logic         overflow1, zero1, ocupado1, pronto1;

    logic         add_sinal2, add_cin2, add_cout2;
    logic [W-1:0] add_a2, add_b2, add_s2, resultado2;
    logic         overflow2, zero2, ocupado2, pronto2;

    always #5 clk = ~clk;

    // External adder models: s,cout = a + (sinal ? ~b : b) + cin
    assign {add_cout1, add_s1} = {1'b0, add_a1} + {1'b0, (add_sinal1 ? ~add_b1 : add_b1)} + {7'b0, add_cin1};
    assign {add_cout2, add_s2} = {1'b0, add_a2} + {1'b0, (add_sinal2 ? ~add_b2 : add_b2)} + {7'b0, add_cin2};

    controle_somador_complemento7b #(.LARGURA(W), .NORMALIZA_ZERO(1'b1)) dut1 (
        .clk(clk), .rst(rst), .inicio(inicio), .sinal(sinal), .acumula(acumula),
        .a(a), .b(b),
        .add_sinal(add_sinal1), .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1),
        .add_s(add_s1), .add_cout(add_cout1),
        .resultado(resultado1), .overflow(overflow1), .zero(zero1),
        .ocupado(ocupado1), .pronto(pronto1)
    );

    controle_somador_complemento7b #(.LARGURA(W), .NORMALIZA_ZERO(1'b0)) dut2 (
        .clk(clk), .rst(rst), .inicio(inicio), .sinal(sinal), .acumula(acumula),
        .a(a), .b(b),
        .add_sinal(add_sinal2), .add_a(add_a2), .add_b(add_b2), .add_cin(add_cin2),
        .add_s(add_s2), .add_cout(add_cout2),
        .resultado(resultado2), .overflow(overflow2), .zero(zero2),
        .ocupado(ocupado2), .pronto(pronto2)
    );

    typedef struct {
        logic [W-1:0] res;
        logic         ovf;
        logic         zero;
        int           lat;
        logic [W-1:0] res2;
        logic         zero2;
    } esperado_t;

    esperado_t    fila[$];
    int           n_cmp = 0;
    int           n_fail = 0;
    logic [W-1:0] ultimo = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start one operation, follow it to pronto and score it.
    task automatic run_op(
        input logic [W-1:0] ta, input logic [W-1:0] tb_v,
        input logic ts, input logic tacc,
        input logic [W-1:0] eres, input logic eovf, input logic ezero, input int elat,
        input logic [W-1:0] eres2, input logic ezero2,
        input logic extra
    );
        esperado_t    e;
        esperado_t    got;
        logic [W-1:0] a_ef;
        int           ciclos;
        logic         viu_p2;

        a_ef    = tacc ? ultimo : ta;
        e.res   = eres;
        e.ovf   = eovf;
        e.zero  = ezero;
        e.lat   = elat;
        e.res2  = eres2;
        e.zero2 = ezero2;
        fila.push_back(e);

        @(posedge clk); #1;
        a = ta; b = tb_v; sinal = ts; acumula = tacc; inicio = 1'b1;
        @(posedge clk); #1;
        inicio = extra;

        // First cycle of the operation: PASSO1
        check("p1_add_a",     32'(add_a1),     32'(a_ef));
        check("p1_add_b",     32'(add_b1),     32'(tb_v));
        check("p1_add_sinal", 32'(add_sinal1), 32'(ts));
        check("p1_add_cin",   32'(add_cin1),   32'(1'b0));
        check("p1_ocupado",   32'(ocupado1),   32'(1'b1));

        ciclos = 1;
        viu_p2 = 1'b0;
        while (!pronto1 && ciclos < 10) begin
            @(posedge clk); #1;
            ciclos++;
            if (add_cin1 === 1'b1) viu_p2 = 1'b1;
        end

        if (pronto1 !== 1'b1) begin
            check("timeout_pronto", 32'(pronto1), 32'(1'b1));
            void'(fila.pop_front());
        end else begin
            got = fila.pop_front();
            check("latencia",   32'(ciclos),     32'(got.lat));
            check("passo2",     32'(viu_p2),     32'(got.lat == 3));
            check("resultado",  32'(resultado1), 32'(got.res));
            check("overflow",   32'(overflow1),  32'(got.ovf));
            check("zero",       32'(zero1),      32'(got.zero));
            check("ocupado_fim", 32'(ocupado1),  32'(1'b0));
            check("pronto2",    32'(pronto2),    32'(1'b1));
            check("resultado2", 32'(resultado2), 32'(got.res2));
            check("zero2",      32'(zero2),      32'(got.zero2));
            ultimo = got.res;
        end

        // inicio may still be high across the FIM edge; it must be ignored.
        @(posedge clk); #1;
        inicio = 1'b0;
        check("pronto_pulso", 32'(pronto1),  32'(1'b0));
        check("ocioso",       32'(ocupado1), 32'(1'b0));
        if (extra) begin
            @(posedge clk); #1;
            check("sem_reinicio", 32'(ocupado1 | pronto1), 32'(1'b0));
        end
    endtask

    initial begin
        logic viu_pronto;

        rst = 1'b1; inicio = 1'b0; sinal = 1'b0; acumula = 1'b0; a = '0; b = '0;
        #12;
        check("rst_resultado", 32'(resultado1), 32'(7'd0));
        check("rst_overflow",  32'(overflow1),  32'(1'b0));
        check("rst_zero",      32'(zero1),      32'(1'b1));
        check("rst_pronto",    32'(pronto1),    32'(1'b0));
        check("rst_ocupado",   32'(ocupado1),   32'(1'b0));
        check("rst_add_a",     32'(add_a1),     32'(7'd0));
        check("rst_add_cin",   32'(add_cin1),   32'(1'b0));
        @(negedge clk); rst = 1'b0;

        // 5 + 3 = 8, no carry
        run_op(7'd5, 7'd3, 1'b0, 1'b0, 7'b0001000, 1'b0, 1'b0, 2, 7'b0001000, 1'b0, 1'b0);
        // 5 - 3: pass 1 carries, end-around gives 2
        run_op(7'd5, 7'd3, 1'b1, 1'b0, 7'b0000010, 1'b0, 1'b0, 3, 7'b0000010, 1'b0, 1'b0);
        // 3 - 5 = -2
        run_op(7'd3, 7'd5, 1'b1, 1'b0, 7'b1111101, 1'b0, 1'b0, 2, 7'b1111101, 1'b0, 1'b0);
        // 60 + 5 overflows positive
        run_op(7'd60, 7'd5, 1'b0, 1'b0, 7'b1000001, 1'b1, 1'b0, 2, 7'b1000001, 1'b0, 1'b0);
        // -60 + -5 overflows negative, with end-around carry
        run_op(7'b1000011, 7'b1111010, 1'b0, 1'b0, 7'b0111110, 1'b1, 1'b0, 3, 7'b0111110, 1'b0, 1'b0);
        // 5 - 5: -0, normalised in dut1, kept in dut2
        run_op(7'd5, 7'd5, 1'b1, 1'b0, 7'b0000000, 1'b0, 1'b1, 2, 7'b1111111, 1'b1, 1'b0);
        check("ovf2_menos_zero", 32'(overflow2), 32'(1'b0));

        // Accumulate from a fresh reset, with spurious inicio while busy
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        ultimo = '0;
        run_op(7'h55, 7'd4, 1'b0, 1'b1, 7'd4,  1'b0, 1'b0, 2, 7'd4,  1'b0, 1'b1);
        run_op(7'h55, 7'd4, 1'b0, 1'b1, 7'd8,  1'b0, 1'b0, 2, 7'd8,  1'b0, 1'b1);
        run_op(7'h55, 7'd4, 1'b0, 1'b1, 7'd12, 1'b0, 1'b0, 2, 7'd12, 1'b0, 1'b1);

        // Reset during PASSO1 abandons the operation
        @(posedge clk); #1;
        a = 7'd9; b = 7'd1; sinal = 1'b0; acumula = 1'b0; inicio = 1'b1;
        @(posedge clk); #1;
        inicio = 1'b0;
        check("mid_ocupado", 32'(ocupado1), 32'(1'b1));
        rst = 1'b1;
        #1;
        check("mid_rst_resultado", 32'(resultado1), 32'(7'd0));
        check("mid_rst_zero",      32'(zero1),      32'(1'b1));
        check("mid_rst_ocupado",   32'(ocupado1),   32'(1'b0));
        check("mid_rst_pronto",    32'(pronto1),    32'(1'b0));
        check("mid_rst_add_a",     32'(add_a1),     32'(7'd0));
        @(negedge clk); rst = 1'b0;
        viu_pronto = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            viu_pronto = viu_pronto | pronto1 | ocupado1;
        end
        check("mid_sem_pronto", 32'(viu_pronto), 32'(1'b0));

        // Controller is idle again and accepts a new operation
        ultimo = '0;
        run_op(7'd9, 7'd1, 1'b0, 1'b0, 7'd10, 1'b0, 1'b0, 2, 7'd10, 1'b0, 1'b0);

        check("fila_vazia", 32'(fila.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
